// File: rtl/food_eaten_tracker_if.sv
// rtl/food_eaten_tracker_if.sv - Pac-Man eat request channel between game logic, layout ROM and tracker
interface food_eaten_tracker_if;
  logic [9:0] pac_x;
  logic [9:0] pac_y;
  logic       pac_valid;
  logic [7:0] pac_tile;
  logic       pac_food;

  // Game side drives position and the ROM answer; tracker returns the tile to look up
  modport master (
    output pac_x,
    output pac_y,
    output pac_valid,
    output pac_food,
    input  pac_tile
  );

  modport slave (
    input  pac_x,
    input  pac_y,
    input  pac_valid,
    input  pac_food,
    output pac_tile
  );
endinterface

// File: rtl/food_eaten_tracker.sv
// rtl/food_eaten_tracker.sv - eaten-pellet mask, score and level-clear tracking for the food layer
module food_eaten_tracker #(
  parameter int TILES_X      = 16,
  parameter int TILES_Y      = 16,
  parameter int PELLET_TOTAL = 200,
  parameter int SCORE_W      = 16,
  parameter int PTS          = 10
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  input  logic                  new_level,
  food_eaten_tracker_if.slave   pac,
  output logic                  eaten_px,
  output logic [SCORE_W-1:0]    score,
  output logic [7:0]            pellets_left,
  output logic                  level_clear,
  output logic                  busy
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_CLEAR} state_t;

  state_t             state;
  state_t             state_nx;
  logic [7:0]         init_ctr;
  logic               e1_valid;
  logic [255:0]       eaten_mask;
  logic               req_ok;
  logic               eat;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;

  // Same truncating arithmetic as the sprite mapper so both agree on tile borders
  function automatic logic [7:0] tile_idx(input logic [9:0] x, input logic [9:0] y);
    logic [13:0] tx;
    logic [13:0] ty;
    tx = ({4'd0, x} * 14'(TILES_X)) / 14'd640;
    ty = ({4'd0, y} * 14'(TILES_Y)) / 14'd480;
    return 8'(ty * 14'(TILES_X) + tx);
  endfunction

  assign req_ok = pac.pac_valid && (pac.pac_x < 10'd640) && (pac.pac_y < 10'd480);

  // The mask bit written by one eat is registered before the next request reaches
  // its E1 stage, so a back-to-back repeat of the same tile already sees it set.
  assign eat = (state == S_RUN) && e1_valid && pac.pac_food &&
               !eaten_mask[pac.pac_tile] && !new_level;

  assign score_sum = {1'b0, score} + (SCORE_W+1)'(PTS);
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  assign level_clear = (pellets_left == 8'd0);

  // State register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_nx;
  end

  // Next state and status decode; new_level overrides everything
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      S_INIT: begin
        busy = 1'b1;
        if (init_ctr == 8'd255) state_nx = S_RUN;
      end
      S_RUN: begin
        if (eat && (pellets_left == 8'd1)) state_nx = S_CLEAR;
      end
      S_CLEAR: state_nx = S_CLEAR;
      default: state_nx = S_INIT;
    endcase
    if (new_level) state_nx = S_INIT;
  end

  // Eat pipeline, counters and the registered pixel lookup
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      init_ctr     <= 8'd0;
      e1_valid     <= 1'b0;
      score        <= '0;
      pellets_left <= 8'(PELLET_TOTAL);
      pac.pac_tile <= 8'd0;
      eaten_px     <= 1'b0;
    end else begin
      if (new_level) begin
        init_ctr     <= 8'd0;
        e1_valid     <= 1'b0;
        pellets_left <= 8'(PELLET_TOTAL);
      end else begin
        if (state == S_INIT) init_ctr <= init_ctr + 8'd1;
        e1_valid <= (state == S_RUN) && req_ok;
        if ((state == S_RUN) && req_ok) pac.pac_tile <= tile_idx(pac.pac_x, pac.pac_y);
        if (eat) begin
          score        <= score_sat;
          pellets_left <= (pellets_left != 8'd0) ? pellets_left - 8'd1 : 8'd0;
        end
      end
      // Reads the mask before any same-edge write, so a fresh eat shows next cycle
      eaten_px <= (state != S_INIT) && blank && eaten_mask[tile_idx(DrawX, DrawY)];
    end
  end

  // Mask storage: swept clear during INIT, set by an eat in RUN, frozen otherwise
  always_ff @(posedge vga_clk) begin
    if (state == S_INIT)  eaten_mask[init_ctr]     <= 1'b0;
    else if (eat)         eaten_mask[pac.pac_tile] <= 1'b1;
  end

endmodule

// File: tb/tb_food_eaten_tracker.sv
// tb/tb_food_eaten_tracker.sv - scoreboard bench for food_eaten_tracker
module tb_food_eaten_tracker;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        new_level;
  logic        eaten_px;
  logic [15:0] score;
  logic [7:0]  pellets_left;
  logic        level_clear;
  logic        busy;

  food_eaten_tracker_if pac();

  food_eaten_tracker dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .new_level    (new_level),
    .pac          (pac),
    .eaten_px     (eaten_px),
    .score        (score),
    .pellets_left (pellets_left),
    .level_clear  (level_clear),
    .busy         (busy)
  );

  typedef struct {
    int    due;
    string tag;
    int    kind;
    int    exp;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;

  bit  m_mask[256];
  int  m_score;
  int  m_pellets;
  bit  m_run;
  bit  m_init;
  int  m_tile;
  bit  p_valid;
  int  p_tile;
  bit  p_chk;

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  function automatic bit rom(input int t);
    return t < 200;
  endfunction

  function automatic int tile_of(input int x, input int y);
    return (y / 30) * 16 + (x / 40);
  endfunction

  function automatic int tx_of(input int t);
    return (t % 16) * 40 + 20;
  endfunction

  function automatic int ty_of(input int t);
    return (t / 16) * 30 + 15;
  endfunction

  task automatic push(input string tag, input int kind, input int exp);
    sb_t e;
    e.due = cyc + 1; e.tag = tag; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  // Pop every expectation whose output is due at this sample point
  always @(negedge vga_clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      int  act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = int'(score);
        1:       act = int'(pellets_left);
        2:       act = int'(pac.pac_tile);
        3:       act = int'(level_clear);
        default: act = int'(eaten_px);
      endcase
      check(e.tag, act, e.exp);
    end
  end

  task automatic model_reset();
    foreach (m_mask[i]) m_mask[i] = 1'b0;
    m_score = 0; m_pellets = 200; m_run = 1'b1; m_init = 1'b0;
    m_tile = 0; p_valid = 1'b0; p_tile = 0; p_chk = 1'b0;
  endtask

  // One clock of stimulus: answer the ROM for the previous request, issue a new one
  task automatic step(input bit v, input int x, input int y, input bit chk);
    bit run_before;
    @(negedge vga_clk);
    run_before = m_run;
    pac.pac_food = p_valid ? rom(p_tile) : 1'b0;
    if (p_valid && m_run && rom(p_tile) && !m_mask[p_tile]) begin
      m_mask[p_tile] = 1'b1;
      m_score   = (m_score + 10 > 65535) ? 65535 : m_score + 10;
      m_pellets = m_pellets - 1;
      if (m_pellets == 0) m_run = 1'b0;
    end
    if (p_chk) begin
      push("score", 0, m_score);
      push("pellets_left", 1, m_pellets);
      push("level_clear", 3, (m_pellets == 0) ? 1 : 0);
    end
    pac.pac_valid = v;
    pac.pac_x     = 10'(x);
    pac.pac_y     = 10'(y);
    p_valid = v && run_before && (x < 640) && (y < 480);
    if (p_valid) m_tile = tile_of(x, y);
    p_tile = m_tile;
    p_chk  = chk;
    if (v && chk) push("pac_tile", 2, m_tile);
  endtask

  task automatic flush();
    step(0, 0, 0, 1'b0);
    step(0, 0, 0, 1'b0);
  endtask

  task automatic px(input int x, input int y, input bit b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    push("eaten_px", 4, (b && !m_init && m_mask[tile_of(x, y)]) ? 1 : 0);
    step(0, 0, 0, 1'b0);
  endtask

  task automatic eat_all(input bit ck);
    for (int t = 0; t < 200; t++)
      step(1, tx_of(t), ty_of(t), ck || (m_score >= 65400) || t == 199);
    flush();
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (busy && n < 400) begin
      @(negedge vga_clk);
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge vga_clk);
    reset_n = 1'b0;
    pac.pac_valid = 1'b0; pac.pac_food = 1'b0;
    model_reset();
    @(negedge vga_clk);
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_pellets", int'(pellets_left), 200);
    check("rst_level_clear", int'(level_clear), 0);
    check("rst_eaten_px", int'(eaten_px), 0);
    check("rst_pac_tile", int'(pac.pac_tile), 0);
    reset_n = 1'b1;
    wait_run(n);
    check("init_cycles", n, 256);
  endtask

  task automatic next_level();
    int n;
    @(negedge vga_clk);
    new_level = 1'b1;
    pac.pac_valid = 1'b0; pac.pac_food = 1'b0;
    foreach (m_mask[i]) m_mask[i] = 1'b0;
    m_pellets = 200; m_run = 1'b1; m_init = 1'b1; p_valid = 1'b0; p_chk = 1'b0;
    @(negedge vga_clk);
    new_level = 1'b0;
    check("nl_busy", int'(busy), 1);
    check("nl_pellets", int'(pellets_left), 200);
    check("nl_score_kept", int'(score), m_score);
    wait_run(n);
    check("nl_run", int'(busy), 0);
    m_init = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; new_level = 1'b0;
    pac.pac_x = '0; pac.pac_y = '0; pac.pac_valid = 1'b0; pac.pac_food = 1'b0;
    do_reset();

    // First eat: tile 17 then the pixel read over it
    step(1, 45, 35, 1'b1);
    flush();
    px(50, 40, 1'b1);

    // Back-to-back requests to the same tile score once
    step(1, 85, 35, 1'b1);
    step(1, 85, 35, 1'b1);
    flush();

    // Empty tile, out-of-range pac_x, already-eaten tile, blanked pixel
    step(1, 100, 405, 1'b1);
    step(1, 700, 35, 1'b1);
    step(1, 45, 35, 1'b1);
    flush();
    px(50, 40, 1'b0);
    px(130, 40, 1'b1);

    // Reset in the middle of RUN
    do_reset();

    // Clear the level, then poke it while cleared
    eat_all(1'b0);
    step(1, 45, 35, 1'b1);
    flush();
    next_level();
    px(50, 40, 1'b1);

    // Keep clearing levels until the score saturates and stays there
    for (int l = 0; l < 40 && m_score < 65535; l++) begin
      eat_all(1'b0);
      next_level();
    end
    eat_all(1'b1);
    check("score_saturated", int'(score), 65535);

    flush();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
